// File: rtl/shift_unit.sv
// shift_unit: iterative shifter for the ALU datapath (SLL/SRL/SRA).
// Moves one bit position per clock instead of using a barrel shifter.
//
//  state | meaning
//  IDLE  | waiting for start; result holds last completed value
//  SHIFT | one position per clock, cnt holds the remaining shifts
//  DONE  | result freshly loaded, done pulses, back to IDLE next edge
module shift_unit #(
  parameter int n  = 32,
  parameter int sw = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [n-1:0]  a,
  input  logic [sw-1:0] shamt,
  input  logic [1:0]    op,
  output logic          busy,
  output logic          done,
  output logic [n-1:0]  result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [sw-1:0] cnt_one = sw'(1);

  state_t        state;
  state_t        state_nxt;
  logic [n-1:0]  shreg;
  logic [n-1:0]  shifted;
  logic [sw-1:0] cnt;
  logic          dir;
  logic          arith;
  logic          last;

  // single-position shift of the working register; fill bit is the
  // sign only for an arithmetic right shift
  always_comb begin
    shifted = {shreg[n-2:0], 1'b0};
    if (dir) begin
      shifted = {arith & shreg[n-1], shreg[n-1:1]};
    end
  end

  assign last = (cnt == cnt_one);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic and state-decoded outputs
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // datapath: capture operands on accept, shift, load result on last step
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      cnt    <= '0;
      dir    <= 1'b0;
      arith  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= a;
            cnt   <= shamt;
            dir   <= op[0];
            // op 10 decodes as a left shift, so arith only matters with dir
            arith <= op[1] & op[0];
            if (shamt == '0) begin
              result <= a;
            end
          end
        end
        SHIFT: begin
          shreg <= shifted;
          cnt   <= cnt - cnt_one;
          if (last) begin
            result <= shifted;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: scoreboard bench; driver pushes expected results with
// their due edge, monitor pops and compares when the due edge arrives.
module tb_shift_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic [1:0]  op;
  logic        busy;
  logic        done;
  logic [31:0] result;

  shift_unit #(.n(32), .sw(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .shamt  (shamt),
    .op     (op),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  typedef struct {
    logic [31:0] exp;
    int          due;
  } item_t;

  item_t       sb_q[$];
  int          ecount = 0;
  int          errors = 0;
  int          checks = 0;
  bit          m_done_cycle = 1'b0;
  logic [31:0] prev_result;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count rising edges so due cycles can be computed
  always @(posedge clk) ecount <= ecount + 1;

  function automatic logic [31:0] ref_shift(input logic [31:0] av, input int s,
                                            input logic [1:0] ov);
    case (ov)
      2'b01:   return av >> s;
      2'b11:   return 32'($signed(av) >>> s);
      default: return av << s;
    endcase
  endfunction

  function automatic bit model_busy();
    return (sb_q.size() != 0) || m_done_cycle;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (edge %0d)", name, got, exp, ecount);
    end
  endtask

  // monitor: sample #1 after each rising edge
  always begin
    item_t it;
    @(posedge clk);
    #1;
    if (rst) begin
      m_done_cycle = 1'b0;
      chk("reset_result", result, 32'h0);
      chk("reset_busy", {31'b0, busy}, 32'h0);
      chk("reset_done", {31'b0, done}, 32'h0);
    end else begin
      chk("busy", {31'b0, busy}, {31'b0, (sb_q.size() != 0)});
      if (sb_q.size() != 0 && ecount == sb_q[0].due) begin
        it = sb_q.pop_front();
        m_done_cycle = 1'b1;
        chk("done_timing", {31'b0, done}, 32'h1);
        chk("result", result, it.exp);
      end else begin
        m_done_cycle = 1'b0;
        chk("done_spurious", {31'b0, done}, 32'h0);
        chk("result_hold", result, prev_result);
      end
    end
    prev_result = result;
  end

  // called at a negedge with the model idle; returns one negedge later
  task automatic issue(input logic [31:0] av, input int s, input logic [1:0] ov);
    item_t it;
    start = 1'b1;
    a     = av;
    shamt = 5'(s);
    op    = ov;
    it.exp = ref_shift(av, s, ov);
    it.due = ecount + 1 + s;
    sb_q.push_back(it);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    shamt = 5'($urandom_range(0, 31));
    op    = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!model_busy()) return;
      @(negedge clk);
    end
    errors++;
    checks++;
    $display("FAIL wait_idle: got=busy expected=idle within 100 cycles");
  endtask

  initial begin
    item_t it;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    shamt = '0;
    op    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    issue(32'h0000_0001, 31, 2'b00);
    wait_idle();
    issue(32'h8000_0000, 4, 2'b11);
    wait_idle();
    issue(32'h8000_0000, 4, 2'b01);
    wait_idle();
    issue(32'hDEAD_BEEF, 0, 2'b11);
    wait_idle();

    // start held high through SHIFT and DONE: second op only after DONE
    start = 1'b1;
    a     = 32'h0000_000F;
    shamt = 5'd2;
    op    = 2'b00;
    it.exp = 32'h0000_003C;
    it.due = ecount + 1 + 2;
    sb_q.push_back(it);
    @(negedge clk);
    a = 32'hFFFF_FFFF;
    wait_idle();
    it.exp = ref_shift(32'hFFFF_FFFF, 2, 2'b00);
    it.due = ecount + 1 + 2;
    sb_q.push_back(it);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // reset at E3 aborts an SRL by 8
    issue(32'hFFFF_FFFF, 8, 2'b01);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    issue(32'hFFFF_FFFF, 8, 2'b01);
    wait_idle();

    // random operations, some back-to-back
    for (int k = 0; k < 40; k++) begin
      issue($urandom, int'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
